// File: rtl/sobel_pkg.sv
// Shared constants, tap indices and state encoding for the Sobel 3x3 window producer.
package sobel_pkg;

  localparam int DEFAULT_PIXEL_WIDTH = 8;
  localparam int WINDOW_TAPS         = 9;

  // Row-major tap positions: P0 top-left (oldest row) .. P8 bottom-right (newest pixel)
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P3 = 3;
  localparam int P4 = 4;
  localparam int P5 = 5;
  localparam int P6 = 6;
  localparam int P7 = 7;
  localparam int P8 = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  function automatic logic [DEFAULT_PIXEL_WIDTH-1:0] tap_slice(
    input logic [DEFAULT_PIXEL_WIDTH*WINDOW_TAPS-1:0] flat,
    input int unsigned                                idx
  );
    return flat[idx*DEFAULT_PIXEL_WIDTH +: DEFAULT_PIXEL_WIDTH];
  endfunction

endpackage

// File: rtl/sobel_line_ram.sv
// One-line pixel delay: asynchronous read returns the value stored before this cycle's write.
module sobel_line_ram #(
  parameter int DEPTH  = 640,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to 3x3 window generator: two line delays feed a 3-column shift window.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int COL_W       = 10,
  parameter int ROW_W       = 9
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               frame_start,
  input  logic                               pixel_valid,
  input  logic [PIXEL_WIDTH-1:0]             pixel_in,
  output logic                               window_valid,
  output logic [PIXEL_WIDTH*WINDOW_TAPS-1:0] window_flat,
  output logic [ROW_W-1:0]                   win_row,
  output logic [COL_W-1:0]                   win_col,
  output logic                               frame_done,
  output logic                               busy
);

  state_t state, state_next;

  logic [ROW_W-1:0] row, row_next, cur_row;
  logic [COL_W-1:0] col, col_next, cur_col;
  logic             accept, last_pixel, win_ok;

  logic [PIXEL_WIDTH-1:0] line0_rd, line1_rd;
  logic [WINDOW_TAPS-1:0][PIXEL_WIDTH-1:0] taps, taps_next;

  sobel_line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH), .ADDR_W(COL_W)) u_line0 (
    .clk     (clk),
    .we      (accept),
    .addr    (cur_col),
    .wr_data (pixel_in),
    .rd_data (line0_rd)
  );

  sobel_line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH), .ADDR_W(COL_W)) u_line1 (
    .clk     (clk),
    .we      (accept),
    .addr    (cur_col),
    .wr_data (line0_rd),
    .rd_data (line1_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // frame_start overrides the position so a qualifying pixel lands at (0,0), even mid-frame
  always_comb begin
    accept     = pixel_valid && ((state != IDLE) || frame_start);
    cur_row    = frame_start ? '0 : row;
    cur_col    = frame_start ? '0 : col;
    last_pixel = accept && (cur_row == ROW_W'(IMG_HEIGHT-1)) && (cur_col == COL_W'(IMG_WIDTH-1));
    win_ok     = accept && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
    state_next = state;
    row_next   = row;
    col_next   = col;
    if (frame_start) begin
      state_next = PREFILL;
      row_next   = '0;
      col_next   = '0;
    end
    if (accept) begin
      if (cur_col == COL_W'(IMG_WIDTH-1)) begin
        col_next = '0;
        row_next = cur_row + ROW_W'(1);
      end else begin
        col_next = cur_col + COL_W'(1);
        row_next = cur_row;
      end
      if (last_pixel) begin
        state_next = IDLE;
        row_next   = '0;
        col_next   = '0;
      end else if (state_next == PREFILL && row_next == ROW_W'(2)) begin
        state_next = ACTIVE;
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else begin
      row <= row_next;
      col <= col_next;
    end
  end

  always_comb begin
    taps_next     = taps;
    taps_next[P0] = taps[P1];
    taps_next[P1] = taps[P2];
    taps_next[P2] = line1_rd;
    taps_next[P3] = taps[P4];
    taps_next[P4] = taps[P5];
    taps_next[P5] = line0_rd;
    taps_next[P6] = taps[P7];
    taps_next[P7] = taps[P8];
    taps_next[P8] = pixel_in;
  end

  // window_flat is a snapshot taken only for valid windows, so it holds between them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps         <= '0;
      window_flat  <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
    end else begin
      window_valid <= win_ok;
      frame_done   <= last_pixel;
      if (frame_start && !pixel_valid) taps <= '0;
      else if (accept)                 taps <= taps_next;
      if (win_ok) begin
        window_flat <= taps_next;
        win_row     <= cur_row - ROW_W'(1);
        win_col     <= cur_col - COL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed self-checking bench for sobel_window_gen on an 8x6 image with pixel = r*16+c (+offset).
module tb_sobel_window_gen;
  import sobel_pkg::*;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int CW   = 3;
  localparam int RW   = 3;
  localparam int NWIN = (W-2)*(H-2);

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        pixel_valid;
  logic [7:0]  pixel_in;
  logic        window_valid;
  logic [71:0] window_flat;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic        frame_done;
  logic        busy;

  sobel_window_gen #(
    .PIXEL_WIDTH (8),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .COL_W       (CW),
    .ROW_W       (RW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .pixel_valid  (pixel_valid),
    .pixel_in     (pixel_in),
    .window_valid (window_valid),
    .window_flat  (window_flat),
    .win_row      (win_row),
    .win_col      (win_col),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [71:0]   flat;
    logic          fd;
    logic          bsy;
  } win_rec_t;

  win_rec_t win_q[$];
  int fd_count;
  int gap_viol;
  int n_checks = 0;
  int n_fail   = 0;

  // Monitor samples 2 time units after each rising edge
  always @(posedge clk) begin
    logic pv_s;
    pv_s = pixel_valid;
    #2;
    if (window_valid) win_q.push_back({win_row, win_col, window_flat, frame_done, busy});
    if (frame_done) fd_count++;
    if (window_valid && !pv_s) gap_viol++;
  end

  function automatic win_rec_t exp_rec(input logic [7:0] off, input int i);
    win_rec_t e;
    int r, c;
    r = 1 + i / (W-2);
    c = 1 + i % (W-2);
    e.row = RW'(r);
    e.col = CW'(c);
    for (int k = 0; k < 9; k++)
      e.flat[k*8 +: 8] = off + 8'((r-1+k/3)*16 + (c-1+k%3));
    e.fd  = (i == NWIN-1);
    e.bsy = (i != NWIN-1);
    return e;
  endfunction

  task automatic clear_mon();
    win_q.delete();
    fd_count = 0;
    gap_viol = 0;
  endtask

  task automatic cycle(input logic fs, input logic pv, input logic [7:0] px);
    frame_start = fs;
    pixel_valid = pv;
    pixel_in    = px;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] off, input bit gaps, input bit fs_first);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gaps && (c == 0 || $urandom_range(0, 9) < 4))
          repeat ($urandom_range(1, 3)) cycle(1'b0, 1'b0, 8'hA5);
        cycle(fs_first && r == 0 && c == 0, 1'b1, off + 8'(r*16 + c));
      end
    end
    repeat (3) cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    pixel_in = 8'h00;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({window_valid, frame_done, busy, win_row, win_col, window_flat} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vld=%b fd=%b busy=%b row=%0d col=%0d flat=%h, expected all zero",
               window_valid, frame_done, busy, win_row, win_col, window_flat);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_full_frame();
    win_rec_t first, last;
    $display("[TB] full frame, continuous valid");
    clear_mon();
    send_frame(8'h00, 1'b0, 1'b1);
    n_checks++;
    if (win_q.size() !== NWIN) begin
      n_fail++;
      $display("FAIL full_count: got %0d windows expected %0d", win_q.size(), NWIN);
    end
    first = (win_q.size() > 0) ? win_q[0] : '0;
    last  = (win_q.size() > 0) ? win_q[win_q.size()-1] : '0;
    n_checks++;
    if ({first.row, first.col, first.flat} !== {3'd1, 3'd1, 72'h22_21_20_12_11_10_02_01_00}) begin
      n_fail++;
      $display("FAIL full_first: got row=%0d col=%0d flat=%h expected row=1 col=1 flat=222120121110020100",
               first.row, first.col, first.flat);
    end
    n_checks++;
    if ({last.row, last.col, last.flat, last.fd, last.bsy} !== {3'd4, 3'd6, 72'h57_56_55_47_46_45_37_36_35, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL full_last: got row=%0d col=%0d flat=%h fd=%b busy=%b expected row=4 col=6 flat=575655474645373635 fd=1 busy=0",
               last.row, last.col, last.flat, last.fd, last.bsy);
    end
    for (int i = 0; i < win_q.size() && i < NWIN; i++) begin
      n_checks++;
      if (win_q[i] !== exp_rec(8'h00, i)) begin
        n_fail++;
        $display("FAIL full_window %0d: got %h expected %h", i, win_q[i], exp_rec(8'h00, i));
      end
    end
    n_checks++;
    if (fd_count !== 1) begin
      n_fail++;
      $display("FAIL full_frame_done: got %0d pulses expected 1", fd_count);
    end
  endtask

  task automatic test_gaps();
    $display("[TB] full frame with random pixel_valid gaps");
    clear_mon();
    send_frame(8'h00, 1'b1, 1'b1);
    n_checks++;
    if (win_q.size() !== NWIN) begin
      n_fail++;
      $display("FAIL gaps_count: got %0d windows expected %0d", win_q.size(), NWIN);
    end
    for (int i = 0; i < win_q.size() && i < NWIN; i++) begin
      n_checks++;
      if (win_q[i] !== exp_rec(8'h00, i)) begin
        n_fail++;
        $display("FAIL gaps_window %0d: got %h expected %h", i, win_q[i], exp_rec(8'h00, i));
      end
    end
    n_checks++;
    if (gap_viol !== 0) begin
      n_fail++;
      $display("FAIL gaps_idle_valid: got %0d windows during gaps expected 0", gap_viol);
    end
    n_checks++;
    if (fd_count !== 1) begin
      n_fail++;
      $display("FAIL gaps_frame_done: got %0d pulses expected 1", fd_count);
    end
  endtask

  task automatic test_row_start();
    $display("[TB] row start suppression");
    clear_mon();
    for (int idx = 0; idx < W*H; idx++) begin
      int r, c;
      r = idx / W;
      c = idx % W;
      cycle(idx == 0, 1'b1, 8'(r*16 + c));
      if ((r == 2 || r == 3) && c < 2) begin
        n_checks++;
        if (window_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL row_start_valid (%0d,%0d): got %b expected 0", r, c, window_valid);
        end
      end
      if (r == 3 && c == 2) begin
        n_checks++;
        if ({window_valid, busy, win_row, win_col, tap_slice(window_flat, P0), tap_slice(window_flat, P8)}
            !== {1'b1, 1'b1, 3'd2, 3'd1, 8'h10, 8'h32}) begin
          n_fail++;
          $display("FAIL row3_first: got vld=%b busy=%b row=%0d col=%0d p0=%h p8=%h expected vld=1 busy=1 row=2 col=1 p0=10 p8=32",
                   window_valid, busy, win_row, win_col, tap_slice(window_flat, P0), tap_slice(window_flat, P8));
        end
      end
    end
    repeat (3) cycle(1'b0, 1'b0, 8'h00);
    n_checks++;
    if (fd_count !== 1) begin
      n_fail++;
      $display("FAIL row_start_frame_done: got %0d pulses expected 1", fd_count);
    end
  endtask

  task automatic test_abort();
    $display("[TB] frame_start abort at pixel (3,4)");
    for (int idx = 0; idx <= 3*W + 3; idx++)
      cycle(idx == 0, 1'b1, 8'((idx / W)*16 + idx % W));
    clear_mon();
    send_frame(8'h80, 1'b0, 1'b1);
    n_checks++;
    if (win_q.size() !== NWIN) begin
      n_fail++;
      $display("FAIL abort_count: got %0d windows expected %0d", win_q.size(), NWIN);
    end
    for (int i = 0; i < win_q.size() && i < NWIN; i++) begin
      n_checks++;
      if (win_q[i] !== exp_rec(8'h80, i)) begin
        n_fail++;
        $display("FAIL abort_window %0d: got %h expected %h", i, win_q[i], exp_rec(8'h80, i));
      end
    end
    n_checks++;
    if (fd_count !== 1) begin
      n_fail++;
      $display("FAIL abort_frame_done: got %0d pulses expected 1", fd_count);
    end
  endtask

  task automatic test_idle_drop();
    $display("[TB] idle pixels dropped, then frame_start alone");
    clear_mon();
    repeat (5) cycle(1'b0, 1'b1, 8'hEE);
    n_checks++;
    if ({busy, 8'(win_q.size()), 8'(fd_count)} !== {1'b0, 8'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL idle_drop: got busy=%b windows=%0d fd=%0d expected 0/0/0", busy, win_q.size(), fd_count);
    end
    cycle(1'b1, 1'b0, 8'hEE);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_fs_busy: got %b expected 1", busy);
    end
    send_frame(8'h00, 1'b0, 1'b0);
    n_checks++;
    if (win_q.size() !== NWIN) begin
      n_fail++;
      $display("FAIL idle_count: got %0d windows expected %0d", win_q.size(), NWIN);
    end
    for (int i = 0; i < win_q.size() && i < NWIN; i++) begin
      n_checks++;
      if (win_q[i] !== exp_rec(8'h00, i)) begin
        n_fail++;
        $display("FAIL idle_window %0d: got %h expected %h", i, win_q[i], exp_rec(8'h00, i));
      end
    end
  endtask

  task automatic test_async_reset();
    $display("[TB] async reset during ACTIVE");
    clear_mon();
    for (int idx = 0; idx <= 3*W + 4; idx++)
      cycle(idx == 0, 1'b1, 8'((idx / W)*16 + idx % W));
    pixel_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({window_valid, frame_done, busy, win_row, win_col, window_flat} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got vld=%b fd=%b busy=%b row=%0d col=%0d flat=%h expected all zero",
               window_valid, frame_done, busy, win_row, win_col, window_flat);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_mon();
    send_frame(8'h00, 1'b0, 1'b1);
    n_checks++;
    if (win_q.size() !== NWIN) begin
      n_fail++;
      $display("FAIL post_reset_count: got %0d windows expected %0d", win_q.size(), NWIN);
    end
    for (int i = 0; i < win_q.size() && i < NWIN; i++) begin
      n_checks++;
      if (win_q[i] !== exp_rec(8'h00, i)) begin
        n_fail++;
        $display("FAIL post_reset_window %0d: got %h expected %h", i, win_q[i], exp_rec(8'h00, i));
      end
    end
    n_checks++;
    if (fd_count !== 1) begin
      n_fail++;
      $display("FAIL post_reset_frame_done: got %0d pulses expected 1", fd_count);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_full_frame();
    test_gaps();
    test_row_start();
    test_abort();
    test_idle_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
Producer side of the 3x3 window interface consumed by the Sobel gradient stage. It accepts a raster-order pixel stream and buffers two previous lines. It then emits one flattened 3x3 window per interior pixel on window_valid/window_flat. It sits between the camera/pixel source and the Sobel kernel, and owns row/column tracking and frame sequencing.

Parameters:
PIXEL_WIDTH, 8, bits per grey pixel
IMG_WIDTH, 640, pixels per line (>=3)
IMG_HEIGHT, 480, lines per frame (>=3)
COL_W, 10, column counter width (clog2(IMG_WIDTH))
ROW_W, 9, row counter width (clog2(IMG_HEIGHT))

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
frame_start  in  1  first-pixel marker; qualifies with pixel_valid or alone
pixel_valid  in  1  pixel_in valid this cycle (no backpressure)
pixel_in  in  PIXEL_WIDTH  raster-order grey pixel
window_valid  out  1  window_flat valid, single-cycle per window
window_flat  out  PIXEL_WIDTH*9  p0..p8 at slices [8k+7:8k]; p0 top-left, p2 top-right, p6 bottom-left, p8 bottom-right (row-major, top row oldest)
win_row  out  ROW_W  row of window centre pixel
win_col  out  COL_W  column of window centre pixel
frame_done  out  1  one-cycle pulse after last pixel of frame accepted
busy  out  1  high in PREFILL/ACTIVE

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, counters 0, shift window cleared. Line RAM contents are don't-care.
- States: IDLE -> PREFILL on frame_start. PREFILL (rows 0-1) -> ACTIVE when row counter reaches 2. ACTIVE -> IDLE after pixel (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
- Accepted pixel: pixel_valid=1 while state is not IDLE, or pixel_valid=1 with frame_start=1 in any state.
- Pixels in IDLE without frame_start are dropped.
- frame_start with pixel_valid: that pixel is (0,0).
- frame_start alone: counters cleared; the next accepted pixel is (0,0).
- frame_start in PREFILL/ACTIVE aborts the frame. Counters and the window register restart, no frame_done is emitted, and any window pending from the prior frame is suppressed.
- Per accepted pixel at (r,c):
  - Read line0[c] (row r-1) and line1[c] (row r-2).
  - Write line1[c] <= old line0[c] and line0[c] <= pixel_in.
  - Shift the 3-column window left and load the new right column {line1[c], line0[c], pixel_in} into p2/p5/p8.
  - c wraps to 0 at IMG_WIDTH-1 and r increments.
- window_valid: asserted exactly 1 cycle after accepting a pixel with r>=2 and c>=2.
  - Centre is (r-1, c-1), driven on win_row/win_col in the same cycle.
  - No border padding; (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
- Stalls: pixel_valid=0 holds all state, and window_valid=0 that cycle. Gaps of any length are legal, including at line ends.
- Columns 0-1 of each row load the window but never validate it; stale left columns from the prior row are never output.
- frame_done: asserted 1 cycle after the final pixel is accepted, coincident with the last window_valid. busy falls in that same cycle.
- window_flat holds its last value when window_valid=0.
- Widths: pure data movement, no arithmetic on pixels; counters compare against IMG_WIDTH-1/IMG_HEIGHT-1.

Decomposition:
- Shared package sobel_pkg holds:
  - PIXEL_WIDTH default, WINDOW_TAPS=9
  - tap index constants P0..P8 and a tap slice helper
  - state encoding IDLE/PREFILL/ACTIVE
- One natural sub-module: sobel_line_ram, a single-line delay of IMG_WIDTH x PIXEL_WIDTH with read-old-on-write semantics. It is instantiated twice, and inference to BSRAM is permitted.

Test Plan:
(All with IMG_WIDTH=8, IMG_HEIGHT=6, pixel value = r*16+c, continuous pixel_valid.)
- Full frame, continuous valid -> first window_valid 1 cycle after pixel (2,2).
  - Centre (1,1), window_flat p0..p8 = 00,01,02,10,11,12,20,21,22.
  - Exactly 24 windows.
  - Last window centre (4,6) = 0x46 with p8=0x57, coincident with frame_done.
- Random pixel_valid gaps (~40% idle), including gaps straddling line ends -> window sequence identical to the continuous run; no window_valid during gaps.
- Row-start check -> no window_valid after pixels (r,0) and (r,1). First window of row 3 is centre (2,1) with p0=0x10, p8=0x32.
- frame_start mid-frame at pixel (3,4), then a full new frame with offset value +0x80 -> no frame_done for the aborted frame; 24 windows of the new frame, all values from the new frame only.
- Pixels in IDLE without frame_start, then frame_start -> dropped pixels never appear; counts and values match the first test.
- rst pulse during ACTIVE (async, mid-cycle) -> all outputs 0 immediately; subsequent full frame matches the first test exactly.
